// File: rtl/sdram_burst_arbiter.sv
// Burst arbiter between the FIFO trigger stage and the SDRAM command core.
// Issues one write or read burst at a time, tracks fill level and wraps the linear pointers.
module sdram_burst_arbiter #(
    parameter int ADDR_W      = 22,
    parameter int BURST_LEN   = 256,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              init_done,
    input  logic              ref_busy,
    input  logic              wr_trig,
    input  logic              rd_trig,
    output logic              wr_req,
    input  logic              wr_ack,
    input  logic              wr_done,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_req,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   fill_level,
    output logic              busy,
    output logic              overflow,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_BUSY = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_BUSY = 3'd4
    } state_t;

    localparam int                TMO_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_W:0]   FULL_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   BURST_FILL = (ADDR_W + 1)'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
    // Highest fill level at which a whole burst still fits without overrunning unread data.
    localparam logic [ADDR_W:0]   WR_LIMIT   = FULL_WORDS - BURST_FILL;
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]     fill_q, fill_d;
    logic                wr_req_q, wr_req_d;
    logic                rd_req_q, rd_req_d;
    logic                busy_q, busy_d;
    logic                overflow_q, overflow_d;
    logic                timeout_q, timeout_d;
    logic                gate_s;
    logic                tmo_hit_s;

    assign gate_s    = init_done & ~ref_busy;
    assign tmo_hit_s = (tmo_q == TMO_LAST);

    // Next-state, pointer, fill and sticky-flag computation.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        tmo_d      = '0;
        case (state_q)
            S_IDLE: begin
                if (gate_s) begin
                    if (wr_trig && (fill_q <= WR_LIMIT)) begin
                        state_d = S_WR_REQ;
                    end else if (rd_trig && (fill_q >= BURST_FILL)) begin
                        state_d = S_RD_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                    // A refused write still flags overflow even when a read is chosen instead.
                    if (wr_trig && (fill_q > WR_LIMIT)) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_REQ: begin
                if (wr_ack) begin
                    state_d = S_WR_BUSY;
                end else if (tmo_hit_s) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_WR_REQ;
                end
            end
            S_WR_BUSY: begin
                if (wr_done) begin
                    wr_addr_d = wr_addr_q + BURST_STEP;
                    fill_d    = fill_q + BURST_FILL;
                    state_d   = S_IDLE;
                end else if (tmo_hit_s) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_WR_BUSY;
                end
            end
            S_RD_REQ: begin
                if (rd_ack) begin
                    state_d = S_RD_BUSY;
                end else if (tmo_hit_s) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_BUSY: begin
                if (rd_done) begin
                    rd_addr_d = rd_addr_q + BURST_STEP;
                    fill_d    = fill_q - BURST_FILL;
                    state_d   = S_IDLE;
                end else if (tmo_hit_s) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_RD_BUSY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // The watchdog restarts on every state entry and idles at zero.
        if ((state_d == S_IDLE) || (state_d != state_q)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        wr_req_d = (state_d == S_WR_REQ);
        rd_req_d = (state_d == S_RD_REQ);
        busy_d   = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            fill_q     <= '0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            fill_q     <= fill_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign wr_req      = wr_req_q;
    assign rd_req      = rd_req_q;
    assign wr_addr     = wr_addr_q;
    assign rd_addr     = rd_addr_q;
    assign fill_level  = fill_q;
    assign busy        = busy_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter, using a 12-bit address space so the fill/wrap
// scenarios stay short while keeping the 256-word burst and 1023-cycle watchdog.
module tb_sdram_burst_arbiter;

    localparam int AW = 12;
    localparam int BL = 256;
    localparam int TO = 1023;

    logic          sclk = 1'b0;
    logic          s_rst;
    logic          init_done, ref_busy, wr_trig, rd_trig;
    logic          wr_ack, wr_done, rd_ack, rd_done;
    logic          wr_req, rd_req, busy, overflow, timeout_err;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [AW:0]   fill_level;

    int checks = 0;
    int errors = 0;
    int hi;
    int seen;

    sdram_burst_arbiter #(.ADDR_W(AW), .BURST_LEN(BL), .ACK_TIMEOUT(TO)) dut (
        .sclk(sclk), .s_rst(s_rst), .init_done(init_done), .ref_busy(ref_busy),
        .wr_trig(wr_trig), .rd_trig(rd_trig),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_done(wr_done), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_done(rd_done), .rd_addr(rd_addr),
        .fill_level(fill_level), .busy(busy), .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    // Waits for a request, acks after ack_dly cycles, signals done done_dly cycles after the ack.
    task automatic burst(input bit is_wr, input int ack_dly, input int done_dly, output int req_hi);
        int n;
        n = 0;
        while (((is_wr ? wr_req : rd_req) == 1'b0) && (n < 20)) begin
            step();
            n++;
        end
        chk(is_wr ? "wr_req_seen" : "rd_req_seen", 32'(is_wr ? wr_req : rd_req), 32'd1);
        if (is_wr) wr_trig = 1'b0; else rd_trig = 1'b0;
        req_hi = 0;
        repeat (ack_dly) begin
            if (is_wr ? wr_req : rd_req) req_hi++;
            step();
        end
        if (is_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
        if (is_wr ? wr_req : rd_req) req_hi++;
        step();
        wr_ack = 1'b0;
        rd_ack = 1'b0;
        chk(is_wr ? "wr_req_drop" : "rd_req_drop", 32'(is_wr ? wr_req : rd_req), 32'd0);
        repeat (done_dly - 1) step();
        if (is_wr) wr_done = 1'b1; else rd_done = 1'b1;
        step();
        wr_done = 1'b0;
        rd_done = 1'b0;
    endtask

    initial begin
        s_rst = 1'b1; init_done = 1'b0; ref_busy = 1'b0; wr_trig = 1'b0; rd_trig = 1'b0;
        wr_ack = 1'b0; wr_done = 1'b0; rd_ack = 1'b0; rd_done = 1'b0;
        step();
        step();
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        s_rst = 1'b0;

        // No request before init completes
        wr_trig = 1'b1;
        repeat (3) step();
        chk("init_gate", 32'(wr_req), 32'd0);
        init_done = 1'b1;

        // 1: single write burst
        burst(1'b1, 3, 260, hi);
        chk("t1_req_cycles", 32'(hi), 32'd4);
        chk("t1_wr_addr", 32'(wr_addr), 32'd256);
        chk("t1_fill", 32'(fill_level), 32'd256);
        chk("t1_idle", 32'(busy), 32'd0);

        // 2: write priority, read two cycles after wr_done
        wr_trig = 1'b1;
        rd_trig = 1'b1;
        step();
        chk("t2_wr_first", 32'(wr_req), 32'd1);
        chk("t2_rd_held", 32'(rd_req), 32'd0);
        burst(1'b1, 0, 2, hi);
        chk("t2_fill_512", 32'(fill_level), 32'd512);
        chk("t2_rd_not_yet", 32'(rd_req), 32'd0);
        step();
        chk("t2_rd_req", 32'(rd_req), 32'd1);
        chk("t2_rd_addr", 32'(rd_addr), 32'd0);
        burst(1'b0, 0, 2, hi);
        chk("t2_rd_addr_after", 32'(rd_addr), 32'd256);
        chk("t2_fill_after", 32'(fill_level), 32'd256);

        // 3: empty SDRAM blocks reads until a write completes
        rd_trig = 1'b1;
        burst(1'b0, 1, 3, hi);
        chk("t3_fill_0", 32'(fill_level), 32'd0);
        rd_trig = 1'b1;
        seen = 0;
        repeat (6) begin
            step();
            if (rd_req) seen++;
        end
        chk("t3_rd_blocked", 32'(seen), 32'd0);
        wr_trig = 1'b1;
        burst(1'b1, 1, 3, hi);
        burst(1'b0, 0, 2, hi);
        chk("t3_rd_addr", 32'(rd_addr), 32'd768);
        chk("t3_fill", 32'(fill_level), 32'd0);

        // 4: fill to capacity, wrap write pointer, then overflow
        for (int i = 0; i < 16; i++) begin
            wr_trig = 1'b1;
            burst(1'b1, 0, 1, hi);
            if (i == 12) chk("t4_wrap_zero", 32'(wr_addr), 32'd0);
        end
        chk("t4_fill_full", 32'(fill_level), 32'd4096);
        chk("t4_wr_addr", 32'(wr_addr), 32'd768);
        chk("t4_no_ovf_yet", 32'(overflow), 32'd0);
        wr_trig = 1'b1;
        rd_trig = 1'b1;
        step();
        wr_trig = 1'b0;
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_wr_refused", 32'(wr_req), 32'd0);
        chk("t4_rd_same_cycle", 32'(rd_req), 32'd1);
        burst(1'b0, 0, 1, hi);
        chk("t4_fill_drained", 32'(fill_level), 32'd3840);

        // 5: ack never arrives
        wr_trig = 1'b1;
        step();
        wr_trig = 1'b0;
        hi = 0;
        while (wr_req && (hi < 1100)) begin
            hi++;
            step();
        end
        chk("t5_req_cycles", 32'(hi), 32'd1023);
        chk("t5_timeout", 32'(timeout_err), 32'd1);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_wr_addr", 32'(wr_addr), 32'd768);
        chk("t5_fill", 32'(fill_level), 32'd3840);

        // Stray completions in IDLE are ignored
        rd_done = 1'b1;
        wr_done = 1'b1;
        step();
        rd_done = 1'b0;
        wr_done = 1'b0;
        chk("stray_fill", 32'(fill_level), 32'd3840);
        chk("stray_rd_addr", 32'(rd_addr), 32'd1024);

        // 6: refresh gating, then reset mid-burst
        ref_busy = 1'b1;
        wr_trig  = 1'b1;
        repeat (3) step();
        chk("t6_ref_gate", 32'(wr_req), 32'd0);
        ref_busy = 1'b0;
        step();
        chk("t6_req_after_ref", 32'(wr_req), 32'd1);
        wr_trig = 1'b0;
        wr_ack  = 1'b1;
        step();
        wr_ack = 1'b0;
        chk("t6_wr_busy", 32'(busy), 32'd1);
        #2;
        s_rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("t6_rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("t6_rst_fill", 32'(fill_level), 32'd0);
        chk("t6_rst_ovf", 32'(overflow), 32'd0);
        chk("t6_rst_tmo", 32'(timeout_err), 32'd0);
        step();
        s_rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
